// File: rtl/systolic_nxn.sv
// Parametrised NxN output-stationary systolic multiplier, C = A x B with K set by the beat stream.
// Optional SYSTOLIC_SAT_EN: accumulators clamp on overflow instead of wrapping.
module systolic_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*DATA_W-1:0]    a_col,
  input  logic [N*DATA_W-1:0]    b_row,
  output logic [N*N*ACC_W-1:0]   result,
  output logic [N*N-1:0]         carry,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             clr, beat;

  assign clr  = (state == IDLE) && start;
  assign beat = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        LOAD: if (beat && in_last) begin
          state     <= DRAIN;
          in_ready  <= 1'b0;
          drain_cnt <= CNT_W'(2*N-2);
        end
        DRAIN: if (drain_cnt == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a_tap/b_tap[i][j]: operand pair presented to PE(i,j); skew and systolic hops share one chain
  logic [DATA_W-1:0] a_tap [N][N];
  logic [DATA_W-1:0] b_tap [N][N];

  for (genvar i = 0; i < N; i++) begin : g_arow
    logic [DATA_W-1:0] sr [i+N];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int t = 0; t < i+N; t++) sr[t] <= '0;
      end else begin
        sr[0] <= beat ? a_col[i*DATA_W +: DATA_W] : '0;
        for (int t = 1; t < i+N; t++) sr[t] <= sr[t-1];
      end
    end
    for (genvar j = 0; j < N; j++) begin : g_tap
      assign a_tap[i][j] = sr[i+j];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_bcol
    logic [DATA_W-1:0] sr [j+N];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int t = 0; t < j+N; t++) sr[t] <= '0;
      end else begin
        sr[0] <= beat ? b_row[j*DATA_W +: DATA_W] : '0;
        for (int t = 1; t < j+N; t++) sr[t] <= sr[t-1];
      end
    end
    for (genvar i = 0; i < N; i++) begin : g_tap
      assign b_tap[i][j] = sr[j+i];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [2*DATA_W-1:0] ax, bx, prod;
      logic [ACC_W-1:0]    acc, ext;
      logic [ACC_W:0]      sum;
      logic                ovf, cy;

      // sign-extending both factors makes the low 2*DATA_W product bits correct in either mode
      always_comb begin
        ax   = {{DATA_W{(SIGNED != 0) && a_tap[i][j][DATA_W-1]}}, a_tap[i][j]};
        bx   = {{DATA_W{(SIGNED != 0) && b_tap[i][j][DATA_W-1]}}, b_tap[i][j]};
        prod = ax * bx;
        ext  = {ACC_W{(SIGNED != 0) && prod[2*DATA_W-1]}};
        ext[2*DATA_W-1:0] = prod;
        sum  = {1'b0, acc} + {1'b0, ext};
        if (SIGNED != 0)
          ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        else
          ovf = sum[ACC_W];
      end

`ifdef SYSTOLIC_SAT_EN
      logic             sat_q;
      logic [ACC_W-1:0] sat_val;

      always_comb begin
        if (SIGNED != 0)
          sat_val = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
          sat_val = '1;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc   <= '0;
          cy    <= 1'b0;
          sat_q <= 1'b0;
        end else if (clr) begin
          acc   <= '0;
          cy    <= 1'b0;
          sat_q <= 1'b0;
        end else begin
          cy <= cy | ovf;
          if (!sat_q) begin
            if (ovf) begin
              acc   <= sat_val;
              sat_q <= 1'b1;
            end else begin
              acc <= sum[ACC_W-1:0];
            end
          end
        end
      end
`else
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc <= '0;
          cy  <= 1'b0;
        end else if (clr) begin
          acc <= '0;
          cy  <= 1'b0;
        end else begin
          acc <= sum[ACC_W-1:0];
          cy  <= cy | ovf;
        end
      end
`endif

      assign result[(i*N+j)*ACC_W +: ACC_W] = acc;
      assign carry[i*N+j]                   = cy;
    end
  end

endmodule

// File: tb/tb_systolic_nxn.sv
// Scoreboard bench for systolic_nxn: an unsigned and a signed 4x4 instance driven with directed products.
module tb_systolic_nxn;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 64;

  typedef struct {
    int                  d;
    logic [N*N*AW-1:0]   res;
    logic [N*N-1:0]      cy;
    longint              cyc;
  } exp_t;

  logic clk, rst;
  logic st [2], iv [2], il [2], ir [2], by [2], dn [2];
  logic [N*DW-1:0]   ac [2], br [2];
  logic [N*N*AW-1:0] res [2];
  logic [N*N-1:0]    cy [2];

  int     n_chk, n_fail;
  longint cyc;
  exp_t   exp_q [$];
  bit     prev_dn [2];

  logic [N*N*AW-1:0] ex_res;
  logic [N*N-1:0]    ex_cy;

  systolic_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .start(st[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_last(il[0]),
    .a_col(ac[0]), .b_row(br[0]), .result(res[0]), .carry(cy[0]), .busy(by[0]), .done(dn[0]));

  systolic_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .start(st[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_last(il[1]),
    .a_col(ac[1]), .b_row(br[1]), .result(res[1]), .carry(cy[1]), .busy(by[1]), .done(dn[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_res(input int d, input string tag, input logic [N*N*AW-1:0] e);
    for (int k = 0; k < N*N; k++)
      chk($sformatf("%s_d%0d_c%0d", tag, d, k), res[d][k*AW +: AW], e[k*AW +: AW]);
  endtask

  function automatic logic [N*DW-1:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic void clear_ex();
    ex_res = '0;
    ex_cy  = '0;
  endfunction

  function automatic void set_ex(input int i, input int j, input longint v);
    ex_res[(i*N+j)*AW +: AW] = v;
  endfunction

  // Scoreboard monitor: every done pulse pops one expected product
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (dn[d]) begin
        chk($sformatf("done_one_cycle_d%0d", d), 64'(prev_dn[d]), 64'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: dut %0d pulsed done with nothing expected", d);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("done_dut", 64'(d), 64'(x.d));
          for (int k = 0; k < N*N; k++)
            chk($sformatf("mon_res_d%0d_c%0d", d, k), res[d][k*AW +: AW], x.res[k*AW +: AW]);
          chk($sformatf("mon_carry_d%0d", d), 64'(cy[d]), 64'(x.cy));
          chk($sformatf("done_latency_d%0d", d), 64'(cyc), 64'(x.cyc));
        end
      end
      prev_dn[d] = dn[d];
    end
  end

  // Called at a negedge; the posedge that follows samples start
  task automatic start_op(input int d);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  // Called at a negedge; the beat is accepted at the following posedge
  task automatic send(input int d, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                      input bit v, input bit l);
    exp_t x;
    ac[d] = a; br[d] = b; iv[d] = v; il[d] = l;
    if (v) chk($sformatf("in_ready_d%0d", d), 64'(ir[d]), 64'd1);
    if (v && l && ir[d]) begin
      x.d = d; x.res = ex_res; x.cy = ex_cy; x.cyc = cyc + 1 + 2*N - 1;
      exp_q.push_back(x);
    end
    @(negedge clk);
    iv[d] = 1'b0; il[d] = 1'b0; ac[d] = '0; br[d] = '0;
  endtask

  task automatic wait_done(input int d);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (dn[d]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: dut %0d never pulsed done", d);
    end
  endtask

  task automatic run_2x2(input int d);
    clear_ex();
    set_ex(0, 0, 7); set_ex(0, 1, 10); set_ex(1, 0, 15); set_ex(1, 1, 22);
    start_op(d);
    send(d, pack4(1, 3, 0, 0), pack4(1, 2, 0, 0), 1, 0);
    send(d, pack4(2, 4, 0, 0), pack4(3, 4, 0, 0), 1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [N*DW-1:0] a, b;
    bit saw;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; iv[d] = 0; il[d] = 0; ac[d] = '0; br[d] = '0; prev_dn[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_in_ready_d%0d", d), 64'(ir[d]), 64'd0);
      chk($sformatf("rst_busy_d%0d", d), 64'(by[d]), 64'd0);
      chk($sformatf("rst_done_d%0d", d), 64'(dn[d]), 64'd0);
      chk($sformatf("rst_carry_d%0d", d), 64'(cy[d]), 64'd0);
      chk_res(d, "rst_res", '0);
    end
    rst = 1'b1;
    @(negedge clk);

    // 2x2 product embedded in the top-left corner
    run_2x2(0);
    chk("drain_in_ready", 64'(ir[0]), 64'd0);
    chk("drain_busy", 64'(by[0]), 64'd1);
    wait_done(0);
    chk("done_busy", 64'(by[0]), 64'd1);
    @(negedge clk);
    chk("idle_busy", 64'(by[0]), 64'd0);

    // Identity x B with a bubble (carrying a stray in_last) between beats 1 and 2
    clear_ex();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_ex(r, c, r*4 + c + 1);
    start_op(0);
    chk("load_busy", 64'(by[0]), 64'd1);
    chk_res(0, "start_clears", '0);
    for (int k = 0; k < N; k++) begin
      a = '0; b = '0;
      a[k*DW +: DW] = 32'd1;
      for (int j = 0; j < N; j++) b[j*DW +: DW] = 32'(k*4 + j + 1);
      send(0, a, b, 1, k == N-1);
      if (k == 1) send(0, '0, '0, 0, 1);
    end
    wait_done(0);
    @(negedge clk);

    // Signed product on the signed instance
    clear_ex();
    set_ex(0, 0, 9); set_ex(0, 1, 22); set_ex(1, 0, -13); set_ex(1, 1, -50);
    start_op(1);
    send(1, pack4(-1, 3, 0, 0), pack4(5, -6, 0, 0), 1, 0);
    send(1, pack4(2, -4, 0, 0), pack4(7, 8, 0, 0), 1, 1);
    wait_done(1);
    @(negedge clk);

    // Overflow: K=3 beats of all-ones elements in the top-left 2x2
    clear_ex();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
`ifdef SYSTOLIC_SAT_EN
        set_ex(r, c, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        set_ex(r, c, 64'hFFFF_FFFA_0000_0003);
`endif
    ex_cy = 16'h0033;
    start_op(0);
    for (int k = 0; k < 3; k++)
      send(0, pack4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0), pack4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0), 1, k == 2);
    wait_done(0);
    @(negedge clk);

    // start pulsed during LOAD (on a bubble) and during DONE must be ignored
    clear_ex();
    set_ex(0, 0, 7); set_ex(0, 1, 10); set_ex(1, 0, 15); set_ex(1, 1, 22);
    start_op(0);
    send(0, pack4(1, 3, 0, 0), pack4(1, 2, 0, 0), 1, 0);
    st[0] = 1'b1;
    send(0, '0, '0, 0, 0);
    st[0] = 1'b0;
    send(0, pack4(2, 4, 0, 0), pack4(3, 4, 0, 0), 1, 1);
    wait_done(0);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("done_start_busy", 64'(by[0]), 64'd0);
    chk("done_start_in_ready", 64'(ir[0]), 64'd0);
    chk_res(0, "result_held", ex_res);

    // K=1 outer product
    clear_ex();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) set_ex(r, c, (r+1) * (c+5));
    start_op(0);
    send(0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1, 1);
    wait_done(0);
    @(negedge clk);

    // Reset during DRAIN aborts without a done pulse
    run_2x2(0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(ir[0]), 64'd0);
    chk("abort_busy", 64'(by[0]), 64'd0);
    chk("abort_done", 64'(dn[0]), 64'd0);
    chk("abort_carry", 64'(cy[0]), 64'd0);
    chk_res(0, "abort_res", '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (dn[0]) saw = 1'b1;
    end
    chk("abort_no_done", 64'(saw), 64'd0);

    run_2x2(0);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_nxn.md
Name: systolic_nxn

Overview:
- Parametrised NxN output-stationary systolic matrix multiplier; successor to the fixed 2x2 array.
- Computes C = A x B for A (NxK) and B (KxN); K is arbitrary and set by the stream length.
- Input skew registers are internal, so the host presents one unskewed column of A and one row of B per beat, under a valid/ready handshake.
- Sits between the operand buffers and the result writeback; exposes busy/done for the host controller.

Parameters:
- N, 4, array dimension (rows = cols), 2..8
- DATA_W, 32, operand element width
- ACC_W, 64, accumulator/result width, must be >= 2*DATA_W
- SIGNED, 0, 1 = two's-complement operands and accumulators, 0 = unsigned

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin new product; sampled only in IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  marks final beat (k = K-1)
- a_col  in  N*DATA_W  A[i][k], element i at bits [i*DATA_W +: DATA_W]
- b_row  in  N*DATA_W  B[k][j], element j at bits [j*DATA_W +: DATA_W]
- result  out  N*N*ACC_W  C[i][j] at index (i*N+j)*ACC_W
- carry  out  N*N  sticky per-PE overflow, index i*N+j
- busy  out  1  high in LOAD/DRAIN/DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all accumulators, skew/pipeline registers, result, carry, done, busy, in_ready = 0.
- FSM IDLE: start=1 -> clear all accumulators and carry (synchronous), go to LOAD.
- FSM LOAD: in_ready=1. An accepted beat enters skew stage 0. in_valid=0 injects a zero bubble that propagates harmlessly. Accepted beat with in_last=1 -> DRAIN, drain counter loaded with 2N-2.
- FSM DRAIN: in_ready=0; counter decrements each cycle; at 0 -> DONE.
- FSM DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Skew: row i of A is delayed i cycles; column j of B is delayed j cycles. A moves right and B moves down, one register per PE.
- PE(i,j) sees A[i][k] and B[k][j] together i+j cycles after beat k is accepted.
- PE(i,j): acc <= acc + a*b, product full 2*DATA_W, sign- or zero-extended to ACC_W per SIGNED.
- carry[i*N+j]: sticky. Set on unsigned carry-out (SIGNED=0) or signed overflow (SIGNED=1) of any accumulate. Cleared only by start or reset.
- Latency: if the in_last beat is accepted at edge E, done is high in the cycle after edge E+2N-1.
- result is final and stable from the done cycle until the next start is accepted.
- result is combinationally the accumulator array and may change during LOAD/DRAIN.
- K=1 (start, then a single beat with in_last) is legal.
- in_last on a bubble (in_valid=0) has no effect.
- Reset mid-operation aborts immediately, with no done pulse.

Optional Feature:
- Macro SYSTOLIC_SAT_EN.
- Defined: on an overflowing accumulate, the accumulator clamps to its max (or min when SIGNED=1 and overflow is negative) and stays clamped for the rest of the product. carry behaves as without the macro.
- Undefined: the accumulator wraps modulo 2^ACC_W.

Test Plan:
- N=2, SIGNED=0: A=B=[1 2;3 4]; beats (a_col,b_row) = ({1,3},{1,2}), then ({2,4},{3,4}) with in_last -> result [7 10;15 22], carry=0, done exactly 3 cycles after last accept.
- N=4: A=identity, B[r][c]=r*4+c+1, 4 beats with in_valid dropped one cycle between beats 1 and 2 -> result equals B; done timing measured from last accept only.
- N=2, SIGNED=1: A=[-1 2;3 -4], B=[5 -6;7 8] -> result [9 22;-13 -50] as 64-bit two's complement; carry=0.
- N=2, DATA_W=32, ACC_W=64, SIGNED=0: K=3 beats, all elements 0xFFFFFFFF -> without macro every carry=1 and accumulators wrap; with SYSTOLIC_SAT_EN every result = 0xFFFFFFFFFFFFFFFF, carry=1.
- Assert rst low during DRAIN -> all outputs 0 asynchronously, no done pulse. A fresh start with the K=2 case above then yields the correct [7 10;15 22].
- start pulsed during LOAD and DONE -> ignored, no accumulator clear. A second start after IDLE clears the previous result before new accumulation.
